// File: rtl/lag_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lag_timer_if
//  Description : Result hand-off bundle between lag_timer (master) and the
//                on-screen readout (slave): per-channel counts, hit flags and
//                a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lag_timer_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 24
);
    logic [CHANNELS*CNT_W-1:0] result;
    logic [CHANNELS-1:0]       hit;
    logic                      result_valid;
    logic                      result_ready;

    // Producer side: the measurement engine.
    modport master (
        output result,
        output hit,
        output result_valid,
        input  result_ready
    );

    // Consumer side: the readout.
    modport slave (
        input  result,
        input  hit,
        input  result_valid,
        output result_ready
    );
endinterface
`default_nettype wire

// File: rtl/lag_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lag_timer
//  Description : Multi-channel input-lag measurement engine. A start arms the
//                block, each enabled channel counts cycles until its debounced
//                sensor edge, and the results are handed off over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module lag_timer #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 24,
    parameter int DEB_LEN    = 4,
    parameter int TIMEOUT    = 6000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                start,
    input  wire logic [CHANNELS-1:0] ch_en,
    input  wire logic [CHANNELS-1:0] sensor,
    output logic                     busy,
    output logic                     start_err,
    lag_timer_if.master              res_if
);

    // Raw level that means "no light seen" on every channel.
    localparam logic [CHANNELS-1:0] c_IDLE_LVL = {CHANNELS{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]    c_TIMEOUT  = CNT_W'(TIMEOUT);
    // Cycles between the raw sample edge and the detection edge that are
    // already on the counter when a detection is latched: two synchroniser
    // flops plus DEB_LEN debounce samples, minus the detection register.
    localparam logic [CNT_W-1:0]    c_LAT      = CNT_W'(DEB_LEN + 1);
    localparam logic [3:0]          c_DEB      = 4'(DEB_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [CHANNELS-1:0]       r_sync1;
    logic [CHANNELS-1:0]       r_sync2;
    logic [CHANNELS-1:0]       w_act;
    logic [CHANNELS-1:0]       w_deb_full;
    logic [CHANNELS-1:0]       w_det_now;

    logic [CNT_W-1:0]          r_cnt;
    logic [CHANNELS-1:0]       r_en;
    logic [CHANNELS-1:0]       r_det;
    logic [CHANNELS*CNT_W-1:0] r_result;
    logic                      r_start_err;

    logic                      w_accept;
    logic                      w_reject;
    logic                      w_start_blk;
    logic                      w_all_det;
    logic                      w_timeout;
    logic                      w_valid;
    logic [CNT_W-1:0]          w_lat_val;

    // Two-flop synchroniser on the raw sensor pins, parked at the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= c_IDLE_LVL;
            r_sync2 <= c_IDLE_LVL;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity so that 1 always means "sensor active".
    assign w_act = r_sync2 ^ c_IDLE_LVL;

    // Per-channel debounce: count consecutive active samples, saturate at
    // DEB_LEN, and drop back to zero on any inactive sample.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [3:0] r_deb;

        // Debounce run-length counter for this channel.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_deb <= 4'd0;
            end else if (!w_act[c]) begin
                r_deb <= 4'd0;
            end else if (r_deb != c_DEB) begin
                r_deb <= r_deb + 4'd1;
            end
        end

        assign w_deb_full[c] = (r_deb == c_DEB);
    end

    // A channel detects at most once per measurement, and only while counting.
    assign w_det_now   = (r_state == ST_COUNT) ? (w_deb_full & r_en & ~r_det) : '0;
    assign w_start_blk = |(w_act & ch_en);
    assign w_all_det   = &(r_det | ~r_en);
    assign w_timeout   = (r_cnt == c_TIMEOUT);
    // A sensor already switching as the start lands would come out negative;
    // clamp it to zero rather than wrapping.
    assign w_lat_val   = (r_cnt >= c_LAT) ? (r_cnt - c_LAT) : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        busy        = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_start_blk) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                busy = 1'b1;
                if (w_all_det || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                w_valid = 1'b1;
                if (res_if.result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Measurement datapath: cycle counter, enable latch, detect flags and
    // per-channel results. Results only move while counting, so they stay
    // frozen through DONE and afterwards until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_en        <= '0;
            r_det       <= '0;
            r_result    <= '0;
            r_start_err <= 1'b0;
        end else begin
            r_start_err <= w_reject;
            if (w_accept) begin
                r_cnt    <= '0;
                r_en     <= ch_en;
                r_det    <= '0;
                r_result <= '0;
            end else if (r_state == ST_COUNT) begin
                if (!w_timeout) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_det <= r_det | w_det_now;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_det_now[c]) begin
                        r_result[c*CNT_W +: CNT_W] <= w_lat_val;
                    end else if (w_timeout && r_en[c] && !r_det[c]) begin
                        r_result[c*CNT_W +: CNT_W] <= '1;
                    end
                end
            end
        end
    end

    assign start_err           = r_start_err;
    assign res_if.result       = r_result;
    assign res_if.hit          = r_det;
    assign res_if.result_valid = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_lag_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lag_timer
//  Description : Directed self-checking bench for lag_timer (2 channels,
//                DEB_LEN=4, TIMEOUT=1000, active-low sensors).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lag_timer;

    localparam int CH  = 2;
    localparam int CW  = 24;
    localparam int DEB = 4;
    localparam int TO  = 1000;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start  = 1'b0;
    logic [CH-1:0] ch_en  = '0;
    logic [CH-1:0] sensor = '1;
    logic          busy;
    logic          start_err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int e0         = 0;
    int lat        = 0;

    lag_timer_if #(.CHANNELS(CH), .CNT_W(CW)) rif ();

    lag_timer #(
        .CHANNELS  (CH),
        .CNT_W     (CW),
        .DEB_LEN   (DEB),
        .TIMEOUT   (TO),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ch_en    (ch_en),
        .sensor   (sensor),
        .busy     (busy),
        .start_err(start_err),
        .res_if   (rif)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge E0+n it reads e0+n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [CH-1:0] en);
        ch_en = en;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (rif.result_valid === 1'b1) begin
                at = cyc - e0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic ack();
        rif.result_ready = 1'b1;
        tick(1);
        rif.result_ready = 1'b0;
    endtask

    task automatic idle_sensors();
        sensor = '1;
        tick(4);
    endtask

    task automatic test_reset();
        tick(2);
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); mismatched++; end
        compared++;
        if (rif.result_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", rif.result_valid); mismatched++; end
        compared++;
        if (rif.result !== '0 || rif.hit !== '0 || start_err !== 1'b0) begin
            $display("FAIL reset_outputs: result=%h hit=%b start_err=%b want all 0", rif.result, rif.hit, start_err);
            mismatched++;
        end
        compared++;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        launch(2'b01);
        tick(99);
        sensor[0] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 107) begin $display("FAIL single_latency: got %0d want 107", lat); mismatched++; end
        compared++;
        if (rif.result[CW-1:0] !== 24'd100) begin $display("FAIL single_r0: got %0d want 100", rif.result[CW-1:0]); mismatched++; end
        compared++;
        if (rif.result[2*CW-1:CW] !== 24'd0) begin $display("FAIL single_r1: got %0d want 0", rif.result[2*CW-1:CW]); mismatched++; end
        compared++;
        if (rif.hit !== 2'b01) begin $display("FAIL single_hit: got %b want 01", rif.hit); mismatched++; end
        compared++;
        if (busy !== 1'b1) begin $display("FAIL single_busy_done: got %b want 1", busy); mismatched++; end
        compared++;
        ack();
        if (rif.result_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_handshake: valid=%b busy=%b want 0 0", rif.result_valid, busy);
            mismatched++;
        end
        compared++;
        if (rif.result[CW-1:0] !== 24'd100 || rif.hit !== 2'b01) begin
            $display("FAIL single_hold_after_ack: r0=%0d hit=%b want 100 01", rif.result[CW-1:0], rif.hit);
            mismatched++;
        end
        compared++;
        idle_sensors();
    endtask

    task automatic test_two_channels();
        logic stable;
        launch(2'b11);
        tick(49);
        sensor[0] = 1'b0;
        tick(250);
        sensor[1] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 307) begin $display("FAIL two_latency: got %0d want 307", lat); mismatched++; end
        compared++;
        if (rif.result !== {24'd300, 24'd50}) begin
            $display("FAIL two_results: got r1=%0d r0=%0d want 300 50", rif.result[2*CW-1:CW], rif.result[CW-1:0]);
            mismatched++;
        end
        compared++;
        if (rif.hit !== 2'b11) begin $display("FAIL two_hit: got %b want 11", rif.hit); mismatched++; end
        compared++;
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (rif.result !== {24'd300, 24'd50} || rif.hit !== 2'b11 || busy !== 1'b1 || rif.result_valid !== 1'b1)
                stable = 1'b0;
        end
        if (stable !== 1'b1) begin
            $display("FAIL two_hold_stable: got result=%h hit=%b busy=%b valid=%b want stable", rif.result, rif.hit, busy, rif.result_valid);
            mismatched++;
        end
        compared++;
        ack();
        idle_sensors();
    endtask

    task automatic test_glitch();
        launch(2'b01);
        tick(9);
        sensor[0] = 1'b0;
        tick(3);
        sensor[0] = 1'b1;
        tick(27);
        sensor[0] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 47) begin $display("FAIL glitch_latency: got %0d want 47", lat); mismatched++; end
        compared++;
        if (rif.result[CW-1:0] !== 24'd40) begin $display("FAIL glitch_r0: got %0d want 40", rif.result[CW-1:0]); mismatched++; end
        compared++;
        ack();
        idle_sensors();
    endtask

    task automatic test_timeout();
        launch(2'b11);
        wait_valid(1100, lat);
        if (lat !== 1001) begin $display("FAIL timeout_latency: got %0d want 1001", lat); mismatched++; end
        compared++;
        if (rif.result !== {24'hFFFFFF, 24'hFFFFFF}) begin $display("FAIL timeout_results: got %h want all ones", rif.result); mismatched++; end
        compared++;
        if (rif.hit !== 2'b00) begin $display("FAIL timeout_hit: got %b want 00", rif.hit); mismatched++; end
        compared++;
        ack();
        idle_sensors();
    endtask

    task automatic test_rejected_start();
        sensor[0] = 1'b0;
        tick(4);
        ch_en = 2'b01;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (start_err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reject_pulse: start_err=%b busy=%b want 1 0", start_err, busy);
            mismatched++;
        end
        compared++;
        tick(1);
        if (start_err !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reject_pulse_end: start_err=%b busy=%b want 0 0", start_err, busy);
            mismatched++;
        end
        compared++;
        idle_sensors();
    endtask

    task automatic test_ignored_start();
        launch(2'b01);
        tick(19);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (start_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL ignored_start: start_err=%b busy=%b want 0 1", start_err, busy);
            mismatched++;
        end
        compared++;
        tick(39);
        sensor[0] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 67 || rif.result[CW-1:0] !== 24'd60) begin
            $display("FAIL ignored_result: latency=%0d r0=%0d want 67 60", lat, rif.result[CW-1:0]);
            mismatched++;
        end
        compared++;
        ack();
        idle_sensors();
    endtask

    task automatic test_back_to_back();
        launch(2'b00);
        wait_valid(10, lat);
        if (lat !== 1) begin $display("FAIL zero_en_latency: got %0d want 1", lat); mismatched++; end
        compared++;
        if (rif.result !== '0 || rif.hit !== 2'b00) begin
            $display("FAIL zero_en_results: result=%h hit=%b want 0 00", rif.result, rif.hit);
            mismatched++;
        end
        compared++;
        rif.result_ready = 1'b1;
        tick(1);
        rif.result_ready = 1'b0;
        launch(2'b01);
        if (busy !== 1'b1) begin $display("FAIL b2b_accept: busy=%b want 1", busy); mismatched++; end
        compared++;
        tick(4);
        sensor[0] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 12 || rif.result[CW-1:0] !== 24'd5) begin
            $display("FAIL b2b_result: latency=%0d r0=%0d want 12 5", lat, rif.result[CW-1:0]);
            mismatched++;
        end
        compared++;
        ack();
        idle_sensors();
    endtask

    task automatic test_async_reset();
        launch(2'b01);
        tick(60);
        reset = 1'b1;
        #1;
        if (busy !== 1'b0 || rif.result_valid !== 1'b0 || rif.result !== '0 || rif.hit !== '0 || start_err !== 1'b0) begin
            $display("FAIL async_reset: busy=%b valid=%b result=%h hit=%b want all 0", busy, rif.result_valid, rif.result, rif.hit);
            mismatched++;
        end
        compared++;
        tick(2);
        reset = 1'b0;
        launch(2'b01);
        if (busy !== 1'b1) begin $display("FAIL post_reset_accept: busy=%b want 1", busy); mismatched++; end
        compared++;
        tick(29);
        sensor[0] = 1'b0;
        wait_valid(50, lat);
        if (lat !== 37 || rif.result[CW-1:0] !== 24'd30 || rif.hit !== 2'b01) begin
            $display("FAIL post_reset_result: latency=%0d r0=%0d hit=%b want 37 30 01", lat, rif.result[CW-1:0], rif.hit);
            mismatched++;
        end
        compared++;
        ack();
        idle_sensors();
    endtask

    initial begin
        rif.result_ready = 1'b0;
        test_reset();
        test_single();
        test_two_channels();
        test_glitch();
        test_timeout();
        test_rejected_start();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lag_timer.md
# lag_timer

Multi-channel input-lag measurement engine for the MrLaggy system. A start pulse arms the block when the test pattern changes on screen. Each enabled channel then counts clock cycles until its light sensor, wired to the user port, reports a debounced edge. The block sits in the system clock domain beside the video generator and hands per-channel results to the on-screen readout through a valid/ready handshake.

## Interface
Parameters:
- CHANNELS, 2: number of independent sensor channels (1..7).
- CNT_W, 24: width of each result counter.
- DEB_LEN, 4: consecutive synchronised samples required to accept an active level (1..15).
- TIMEOUT, 6000000: cycle count at which a measurement gives up. Must be less than 2^CNT_W - 1.
- ACTIVE_LOW, 1: 1 means a sensor is active when its raw input is 0, as on the open-drain user port.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  single-cycle request to begin a measurement.
- ch_en  in  CHANNELS  channel enable mask, sampled only when a start is accepted.
- sensor  in  CHANNELS  raw asynchronous sensor inputs.
- busy  out  1  high in COUNT and DONE.
- start_err  out  1  one-cycle pulse when a start is rejected.
- result  out  CHANNELS*CNT_W  channel c's cycle count at [c*CNT_W +: CNT_W].
- hit  out  CHANNELS  1 if the channel detected an edge before timeout.
- result_valid  out  1  result and hit are stable and valid.
- result_ready  in  1  consumer accepts the result.

## Operation
- Input path, per channel:
  - Two-flop synchroniser, then polarity normalisation using ACTIVE_LOW.
  - Debounce counter increments while the synchronised level is active and clears on an inactive sample.
  - Detection fires once per measurement, when the counter reaches DEB_LEN.
- States:
  - **IDLE.** On start: if any enabled channel's synchronised level is active, pulse start_err and stay in IDLE. Otherwise latch ch_en, clear the cycle counter and all detect flags, and go to COUNT. This accepting edge is E0.
  - **COUNT.** Cycle counter = n after edge E0+n.
    - On a channel's detection, latch its value with the fixed pipeline latency subtracted, so the reported value is k. E0+k is the first edge at which the raw input was sampled active and then held for DEB_LEN samples. Set that channel's hit.
    - Go to DONE when every enabled channel has detected, or when the counter equals TIMEOUT.
    - On timeout, undetected enabled channels report all-ones with hit=0.
    - Disabled channels report 0 with hit=0.
  - **DONE.** result_valid=1, and result/hit are held constant. On result_valid & result_ready, go to IDLE and drop result_valid. result and hit keep their values until the next accepted start.
- Simultaneous events:
  - A start while busy is ignored, with no start_err.
  - A start with ch_en=0 is accepted and completes immediately: DONE on the next edge, all results 0, hit=0.
  - Detection on the same edge as the TIMEOUT compare counts as a hit.
  - If several channels detect on the same edge, all are latched.
- Glitches: active pulses shorter than DEB_LEN synchronised samples are never latched.
- Counter arithmetic: unsigned and wraps never. The counter stops at TIMEOUT.

## Timing
- Reset values: busy=0, start_err=0, result=0, hit=0, result_valid=0, state IDLE, synchronisers cleared to the inactive level.
- Reset mid-measurement aborts at once. No result is produced, and start is honoured again on the first edge after reset deasserts.
- busy rises on edge E0 and falls on the handshake edge.
- Detection for a channel with value k happens at edge E0+k+DEB_LEN+2.
- result_valid rises at edge E0+kmax+DEB_LEN+3, where kmax is the largest k among enabled channels. On timeout it rises at edge E0+TIMEOUT+1.
- start_err is high for exactly the cycle after the rejected start edge.
- Back-to-back measurements: a start in the cycle after the handshake edge is accepted.

## Test plan
- **Single-channel measurement.** CHANNELS=2, DEB_LEN=4, ch_en=01. Start, then drive sensor[0] active from edge E0+100 -> result[0]=100, hit=01, result[1]=0, result_valid at E0+107.
- **Two channels, different arrival.** Channel 0 active at k=50, channel 1 at k=300 -> results 50 and 300, hit=11, result_valid at E0+307. Hold result_ready=0 for 20 cycles and confirm outputs stay stable and busy=1.
- **Glitch rejection.** A 3-cycle active pulse at k=10, then a solid edge at k=40 -> result=40.
- **Timeout.** TIMEOUT=1000, no sensor activity, ch_en=11 -> results all-ones, hit=00, result_valid at E0+1001.
- **Rejected and ignored starts.** Start while sensor[0] is already active -> start_err pulses once, busy stays 0. A start pulsed during COUNT -> no effect on the running result.
- **Asynchronous reset.** Assert reset at E0+60 of a measurement -> all outputs 0 in the same cycle. A new start after release measures k correctly from the new E0.
